score_collector_12: RTL and testbench
=====================================

// Module: score_collector_12
// PURPOSE
//  Upstream feeder for the 12-way argmax comparator tree in the comp layer.
//  Collects 12 signed class scores streamed one per beat from the final FC
//  layer into a 12-slot parallel bus, then drives the tree's load for its full
//  pipeline depth. It captures the winning class number (1..12) and holds it
//  for the consumer until acknowledged. Score width is `data_len (num_data.v).
// PARAMETERS
//  N_CLASS    12  scores per frame; fixed, matches the 4-bit class index
//  PIPE_DEPTH 4   comparator tree register stages (6/3/1/1 comparator_2 levels)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst_n        in   1              async active-low reset
//  in_valid     in   1              score beat valid
//  in_first     in   1              beat is class 1 (start of frame)
//  in_data      in   `data_len      signed score
//  in_ready     out  1              block accepts a beat this cycle
//  cmp_d        out  12*`data_len   slot k (class k+1) at [k*`data_len +: `data_len]
//  cmp_load     out  1              load/enable to comparator tree
//  cmp_q        in   4              winning class number from tree
//  class_valid  out  1              class_idx valid, held until class_ack
//  class_idx    out  4              winning class, 1..12
//  class_ack    in   1              consumer takes result
//  frame_err    out  1              1-cycle pulse: frame restarted early
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_COLLECT, slot cnt=0, wait cnt=0,
//   cmp_d=0, cmp_load=0, class_valid=0, class_idx=0, frame_err=0, in_ready=0
//   during reset; in_ready=1 from the first edge after release.
//  Reset mid-frame or mid-compare discards everything; no partial result.
//  FSM S_COLLECT -> S_COMPARE -> S_RESULT -> S_COLLECT.
//  S_COLLECT: in_ready=1. Accept = in_valid&in_ready.
//   in_first=1 on accept: write slot 0, cnt<=1. If cnt!=0 at that moment,
//    pulse frame_err next cycle (partial frame dropped).
//   in_first=0 on accept: write slot cnt, cnt<=cnt+1. in_first=0 with cnt=0
//    is accepted as class 1 (in_first optional on the first frame).
//   Accept with cnt==11 (12th beat): cnt<=0, go S_COMPARE next cycle.
//  S_COMPARE: in_ready=0, cmp_d held stable, cmp_load=1 exactly PIPE_DEPTH
//   cycles (wait counter 0..PIPE_DEPTH-1). Cycle after the last load:
//   class_idx<=cmp_q, class_valid<=1, cmp_load<=0, go S_RESULT.
//  Latency: 12th beat accepted at edge T -> cmp_load high T+1..T+PIPE_DEPTH
//   -> class_valid high from T+PIPE_DEPTH+1.
//  S_RESULT: in_ready=0; class_valid/class_idx held. class_ack=1 -> next
//   cycle class_valid=0, go S_COLLECT. class_ack outside S_RESULT is ignored.
//  No back-to-back overlap: next frame's first beat is accepted no earlier
//   than the cycle after the ack. cmp_d keeps old scores until overwritten.
//  Scores pass bit-exact, no arithmetic. Ties are resolved by the tree.
//  Beats with in_valid=0 leave all state unchanged.
// TESTING
//  1 Scores 0..11 by class, in_first on beat 1 -> class_idx=12, class_valid
//    at T+5 after 12th beat, cmp_load high exactly 4 cycles.
//  2 Scores all -5 except class 3 = +7 (signed) -> class_idx=3. Class 1 = -1,
//    rest = -128 (min) -> 1.
//  3 Random in_valid gaps in one frame -> same result as gapless; in_ready=0
//    throughout compare/result.
//  4 7 beats, then in_first with a new full frame -> frame_err 1-cycle pulse,
//    result from the new frame only.
//  5 class_ack held low 20 cycles -> class_valid/idx stable, in_valid ignored.
//    Ack -> next frame accepted the cycle after.
//  6 rst_n low during S_COMPARE cycle 2 -> all outputs 0 immediately. After
//    release a full frame gives the correct result with no stale load.

Source files
------------

// File: rtl/score_collector_12.sv
// Collects 12 streamed signed class scores into a parallel bus, drives the
// argmax comparator tree load for its pipeline depth, and holds the winning class.
`timescale 1ns/1ps
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module score_collector_12 #(
  parameter int N_CLASS    = 12,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic [`DATA_LEN-1:0]          in_data,
  output logic                          in_ready,
  output logic [N_CLASS*`DATA_LEN-1:0]  cmp_d,
  output logic                          cmp_load,
  input  logic [3:0]                    cmp_q,
  output logic                          class_valid,
  output logic [3:0]                    class_idx,
  input  logic                          class_ack,
  output logic                          frame_err
);

  localparam int DW = `DATA_LEN;
  localparam int WW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_COMPARE,
    S_RESULT
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [WW-1:0]           r_wait;
  logic [N_CLASS*DW-1:0]   r_cmp_d;
  logic                    r_cmp_load;
  logic                    r_in_ready;
  logic                    r_class_valid;
  logic [3:0]              r_class_idx;
  logic                    r_frame_err;

  logic                    w_accept;
  logic [3:0]              w_slot;

  assign w_accept = in_valid & r_in_ready & (r_state == S_COLLECT);
  assign w_slot   = in_first ? 4'd0 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_COLLECT;
      r_cnt         <= '0;
      r_wait        <= '0;
      r_cmp_d       <= '0;
      r_cmp_load    <= 1'b0;
      r_in_ready    <= 1'b0;
      r_class_valid <= 1'b0;
      r_class_idx   <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            for (int unsigned k = 0; k < N_CLASS; k++) begin
              if (w_slot == 4'(k)) r_cmp_d[k*DW +: DW] <= in_data;
            end
            if (in_first) begin
              r_cnt       <= 4'd1;
              r_frame_err <= (r_cnt != 4'd0);
            end else if (r_cnt == 4'(N_CLASS-1)) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_COMPARE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        // Load rises on the first compare edge; wait counts the further loads.
        S_COMPARE: begin
          r_in_ready <= 1'b0;
          if (!r_cmp_load) begin
            r_cmp_load <= 1'b1;
            r_wait     <= '0;
          end else if (r_wait == WW'(PIPE_DEPTH-1)) begin
            r_cmp_load    <= 1'b0;
            r_wait        <= '0;
            r_class_idx   <= cmp_q;
            r_class_valid <= 1'b1;
            r_state       <= S_RESULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_RESULT: begin
          if (class_ack) begin
            r_class_valid <= 1'b0;
            r_in_ready    <= 1'b1;
            r_state       <= S_COLLECT;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign cmp_d       = r_cmp_d;
  assign cmp_load    = r_cmp_load;
  assign class_valid = r_class_valid;
  assign class_idx   = r_class_idx;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_score_collector_12.sv
// Directed bench for score_collector_12; the comparator tree is stood in by a
// first-max argmax over cmp_d.
`timescale 1ns/1ps
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module tb_score_collector_12;

  localparam int DW = `DATA_LEN;
  localparam int NC = 12;

  typedef logic [DW-1:0] frame_t [NC];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_first = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready;
  logic [NC*DW-1:0] cmp_d;
  logic             cmp_load;
  logic [3:0]       cmp_q;
  logic             class_valid;
  logic [3:0]       class_idx;
  logic             class_ack = 1'b0;
  logic             frame_err;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [DW-1:0] best;

  score_collector_12 #(.N_CLASS(12), .PIPE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .in_data(in_data), .in_ready(in_ready), .cmp_d(cmp_d), .cmp_load(cmp_load),
    .cmp_q(cmp_q), .class_valid(class_valid), .class_idx(class_idx),
    .class_ack(class_ack), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_q = 4'd1;
    best  = $signed(cmp_d[DW-1:0]);
    for (int k = 1; k < NC; k++) begin
      if ($signed(cmp_d[k*DW +: DW]) > best) begin
        best  = $signed(cmp_d[k*DW +: DW]);
        cmp_q = 4'(k + 1);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a negedge; waits (bounded) for in_ready before driving.
  task automatic beat(input logic f, input logic [DW-1:0] d, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_first = f;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send(input frame_t s, input int gapped);
    beat(1'b1, s[0], 0);
    for (int k = 1; k < NC; k++) beat(1'b0, s[k], gapped ? (k % 3) : 0);
  endtask

  // Called at the negedge after the 12th beat's accept edge T.
  task automatic finish(input string tag, input frame_t s, input logic [3:0] exp_idx,
                        input int hold);
    logic [NC*DW-1:0] exp_d;
    logic [DW-1:0]    slot0;
    for (int k = 0; k < NC; k++) exp_d[k*DW +: DW] = s[k];
    chk({tag, "_ready_T"}, {127'd0, in_ready}, 128'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk({tag, "_load"}, {127'd0, cmp_load}, 128'd1);
      chk({tag, "_ready_cmp"}, {127'd0, in_ready}, 128'd0);
      chk({tag, "_valid_early"}, {127'd0, class_valid}, 128'd0);
    end
    chk({tag, "_cmp_d"}, {32'd0, cmp_d}, {32'd0, exp_d});
    @(posedge clk); #1;
    chk({tag, "_load_off"}, {127'd0, cmp_load}, 128'd0);
    chk({tag, "_valid"}, {127'd0, class_valid}, 128'd1);
    chk({tag, "_idx"}, {124'd0, class_idx}, {124'd0, exp_idx});
    slot0 = cmp_d[DW-1:0];
    @(negedge clk);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      in_data  = 8'h55;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {127'd0, class_valid}, 128'd1);
      chk({tag, "_hold_idx"}, {124'd0, class_idx}, {124'd0, exp_idx});
      chk({tag, "_hold_ready"}, {127'd0, in_ready}, 128'd0);
      chk({tag, "_hold_slot0"}, {120'd0, cmp_d[DW-1:0]}, {120'd0, slot0});
    end
    if (hold > 0) @(negedge clk);
    in_valid  = 1'b0;
    in_first  = 1'b0;
    class_ack = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_clr"}, {127'd0, class_valid}, 128'd0);
    chk({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    class_ack = 1'b0;
  endtask

  initial begin
    frame_t f1, f2a, f2b, f3, f4old, f4, f6;

    for (int k = 0; k < NC; k++) begin
      f1[k]    = 8'(k);
      f2a[k]   = 8'hFB;
      f2b[k]   = 8'h80;
      f3[k]    = 8'(k * 3);
      f4old[k] = 8'h7F;
      f4[k]    = 8'hF0;
      f6[k]    = 8'(8'hC0 + k);
    end
    f2a[2]  = 8'h07;
    f2b[0]  = 8'hFF;
    f3[6]   = 8'd50;
    f4[9]   = 8'h10;
    f6[4]   = 8'h7F;
    f6[11]  = 8'h7E;

    // Reset state
    #2;
    chk("rst_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_load", {127'd0, cmp_load}, 128'd0);
    chk("rst_valid", {127'd0, class_valid}, 128'd0);
    chk("rst_idx", {124'd0, class_idx}, 128'd0);
    chk("rst_err", {127'd0, frame_err}, 128'd0);
    chk("rst_cmp_d", {32'd0, cmp_d}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);

    // 1: ascending scores -> class 12
    send(f1, 0);
    finish("t1", f1, 4'd12, 0);

    // 2: signed comparisons
    send(f2a, 0);
    finish("t2a", f2a, 4'd3, 0);
    send(f2b, 0);
    finish("t2b", f2b, 4'd1, 0);

    // 3: gapped frame
    send(f3, 1);
    finish("t3", f3, 4'd7, 0);

    // 4: partial frame then restart
    for (int k = 0; k < 7; k++) beat(k == 0, f4old[k], 0);
    beat(1'b1, f4[0], 0);
    chk("t4_err_pulse", {127'd0, frame_err}, 128'd1);
    @(posedge clk); #1;
    chk("t4_err_clear", {127'd0, frame_err}, 128'd0);
    @(negedge clk);
    for (int k = 1; k < NC; k++) beat(1'b0, f4[k], 0);
    chk("t4_no_err", {127'd0, frame_err}, 128'd0);
    finish("t4", f4, 4'd10, 0);

    // 5: long hold with ignored beats, then a frame right after ack
    send(f1, 0);
    finish("t5", f1, 4'd12, 20);
    send(f2a, 0);
    finish("t5b", f2a, 4'd3, 0);

    // 6: reset during compare
    send(f3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_load", {127'd0, cmp_load}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_load", {127'd0, cmp_load}, 128'd0);
    chk("t6_ready", {127'd0, in_ready}, 128'd0);
    chk("t6_valid", {127'd0, class_valid}, 128'd0);
    chk("t6_cmp_d", {32'd0, cmp_d}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_ready", {127'd0, in_ready}, 128'd1);
    chk("t6_rel_load", {127'd0, cmp_load}, 128'd0);
    chk("t6_rel_valid", {127'd0, class_valid}, 128'd0);
    @(negedge clk);
    send(f6, 0);
    finish("t6", f6, 4'd5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
